pipe_regs: RTL and testbench

//  Parametrised elastic pipeline register: DEPTH stages of WIDTH-bit enabled

---
 rtl/pipe_regs.sv | 99 +++++++++
 tb/tb_pipe_regs.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_regs.sv
// Elastic pipeline register: DEPTH stages of WIDTH-bit data with per-stage
// valid bits, a combinational ready chain, synchronous flush and reset value.
module pipe_regs #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  // Handshake: a word moves across a boundary on any edge where the sender's
  // valid and the receiver's ready are both 1; ready never looks at valid of
  // the sender, so in_ready is independent of in_valid.

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] ready;
  logic             in_xfer;
  logic             out_xfer;

  always_comb begin
    ready = '0;
    ready[DEPTH-1] = ~valid_q[DEPTH-1] | out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      ready[i] = ~valid_q[i] | ready[i+1];
    end
  end

  assign in_ready  = ready[0];
  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign count     = count_q;
  assign in_xfer   = in_valid & ready[0];
  assign out_xfer  = valid_q[DEPTH-1] & out_ready;

  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      data_d[i] = data_q[i];
    end
    count_d = count_q;

    if (ready[0]) begin
      valid_d[0] = in_valid;
      if (in_valid) data_d[0] = in_data;
    end
    // Data only moves with a valid word so an emptied stage keeps its last value.
    for (int i = 1; i < DEPTH; i++) begin
      if (ready[i]) begin
        valid_d[i] = valid_q[i-1];
        if (valid_q[i-1]) data_d[i] = data_q[i-1];
      end
    end

    case ({in_xfer, out_xfer})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (flush) begin
      valid_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_d[i] = RESET_VAL;
      end
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RESET_VAL;
      end
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

endmodule

// File: tb/tb_pipe_regs.sv
// Directed bench for pipe_regs (WIDTH=8, DEPTH=3, RESET_VAL=8'hFF) with an
// ordering scoreboard on the output handshake.
module tb_pipe_regs;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;
  localparam logic [WIDTH-1:0] RV = 8'hFF;

  logic             clk = 1'b0;
  logic             reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] in_data, out_data;
  logic [1:0]       count;

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] exp_q[$];

  pipe_regs #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RV)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  always #5 clk = ~clk;

  // Scoreboard: every accepted word must leave once, in order.
  always @(posedge clk) begin
    if (reset === 1'b1 || flush === 1'b1) begin
      exp_q.delete();
    end else begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: got %h, required no output", out_data);
        end else begin
          logic [WIDTH-1:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            bad++;
            $display("FAIL sb_order: got %h, required %h", out_data, e);
          end
        end
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) exp_q.push_back(in_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    // Intentionally not used as a shared helper; kept out of the flow.
  endtask

  task automatic test_reset();
    reset = 1; flush = 0; in_valid = 1; in_data = 8'h55; out_ready = 0;
    step(); step();
    reset = 0; in_valid = 0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
    total++; if (count !== 2'd0) begin bad++; $display("FAIL rst_count: got %0d, required 0", count); end
    total++; if (out_data !== 8'hFF) begin bad++; $display("FAIL rst_out_data: got %h, required ff", out_data); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
  endtask

  task automatic test_stream();
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; in_data = 8'(i + 1);
      step();
      total++;
      if (out_valid !== (i >= 2)) begin bad++; $display("FAIL stream_valid[%0d]: got %b, required %b", i, out_valid, (i >= 2)); end
      if (i >= 2) begin
        total++;
        if (out_data !== 8'(i - 1)) begin bad++; $display("FAIL stream_data[%0d]: got %h, required %h", i, out_data, 8'(i - 1)); end
      end
    end
    in_valid = 0;
    step();
    total++; if (out_data !== 8'h09 || out_valid !== 1'b1) begin bad++; $display("FAIL stream_drain0: got %b/%h, required 1/09", out_valid, out_data); end
    step();
    total++; if (out_data !== 8'h0A || out_valid !== 1'b1) begin bad++; $display("FAIL stream_drain1: got %b/%h, required 1/0a", out_valid, out_data); end
    step();
    total++; if (out_valid !== 1'b0 || count !== 2'd0) begin bad++; $display("FAIL stream_empty: got %b/%0d, required 0/0", out_valid, count); end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] words [4];
    words = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = words[i];
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_accept[%0d]: got in_ready=%b, required 1", i, in_ready); end
      step();
    end
    in_data = words[3];
    #1;
    total++; if (count !== 2'd3) begin bad++; $display("FAIL bp_count: got %0d, required 3", count); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_stall: got in_ready=%b, required 0", in_ready); end
    step(); step();
    total++; if (in_ready !== 1'b0 || out_data !== 8'hA1) begin bad++; $display("FAIL bp_hold: got %b/%h, required 0/a1", in_ready, out_data); end
    out_ready = 1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release: got in_ready=%b, required 1", in_ready); end
    step();
    in_valid = 0;
    for (int i = 1; i < 4; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== words[i]) begin bad++; $display("FAIL bp_drain[%0d]: got %b/%h, required 1/%h", i, out_valid, out_data, words[i]); end
      step();
    end
    total++; if (out_valid !== 1'b0 || count !== 2'd0) begin bad++; $display("FAIL bp_empty: got %b/%0d, required 0/0", out_valid, count); end
  endtask

  task automatic test_bubble();
    out_ready = 0;
    in_valid = 1; in_data = 8'h11; step();
    in_valid = 0; step();
    in_valid = 1; in_data = 8'h22; step();
    in_valid = 0;
    total++; if (count !== 2'd2) begin bad++; $display("FAIL bub_count: got %0d, required 2", count); end
    total++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin bad++; $display("FAIL bub_head: got %b/%h, required 1/11", out_valid, out_data); end
    step();
    out_ready = 1;
    step();
    // 8'h22 must sit directly behind the head, so it follows with no gap.
    total++; if (out_valid !== 1'b1 || out_data !== 8'h22) begin bad++; $display("FAIL bub_second: got %b/%h, required 1/22", out_valid, out_data); end
    step();
    total++; if (out_valid !== 1'b0 || count !== 2'd0) begin bad++; $display("FAIL bub_empty: got %b/%0d, required 0/0", out_valid, count); end
  endtask

  task automatic test_full_simul();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = 8'(8'hB1 + i); step();
    end
    in_data = 8'hB4; out_ready = 1;
    #1;
    total++; if (count !== 2'd3 || in_ready !== 1'b1) begin bad++; $display("FAIL full_pre: got count=%0d in_ready=%b, required 3/1", count, in_ready); end
    step();
    in_valid = 0;
    total++; if (count !== 2'd3 || out_data !== 8'hB2) begin bad++; $display("FAIL full_simul: got count=%0d data=%h, required 3/b2", count, out_data); end
    step(); step(); step();
    total++; if (count !== 2'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL full_drain: got %0d/%b, required 0/0", count, out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 0;
    in_valid = 1; in_data = 8'hC1; step();
    in_data = 8'hC2; step();
    total++; if (count !== 2'd2) begin bad++; $display("FAIL fl_pre: got count=%0d, required 2", count); end
    flush = 1; in_data = 8'hC3;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fl_ready_ungated: got %b, required 1", in_ready); end
    step();
    flush = 0; in_valid = 0;
    total++; if (count !== 2'd0 || out_valid !== 1'b0 || out_data !== 8'hFF) begin bad++; $display("FAIL fl_state: got %0d/%b/%h, required 0/0/ff", count, out_valid, out_data); end
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_ghost[%0d]: got out_valid=%b, required 0", i, out_valid); end
    end
    out_ready = 0;
    in_valid = 1; in_data = 8'hD1; step();
    in_data = 8'hD2; step(); step();
    reset = 1; flush = 1; in_data = 8'hD3;
    step();
    reset = 0; flush = 0; in_valid = 0;
    total++; if (count !== 2'd0 || out_valid !== 1'b0 || out_data !== 8'hFF || in_ready !== 1'b1) begin
      bad++; $display("FAIL rstfl_state: got %0d/%b/%h/%b, required 0/0/ff/1", count, out_valid, out_data, in_ready);
    end
    out_ready = 1; step(); step(); step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstfl_ghost: got out_valid=%b, required 0", out_valid); end
  endtask

  initial begin
    reset = 1; flush = 0; in_valid = 0; in_data = '0; out_ready = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_full_simul();
    test_flush();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d words pending, required 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
